// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone B3 classic initiator: a valid/ready command stream in,
// a valid/ready response stream (read data or timeout error) out.
module wb_initiator #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_offset,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  timer_q, timer_d;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timer_d     = timer_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = BASE_ADDRESS + cmd_offset;
          dat_d   = cmd_we ? cmd_wdata : 32'h0;
          timer_d = 8'h0;
        end
      end
      BUS: begin
        // An ack on the last allowed cycle still counts as success.
        if (wbm_ack_i || timer_q == TIMER_LAST) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          dat_d       = 32'h0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !wbm_ack_i;
          rsp_rdata_d = (wbm_ack_i && !we_q) ? wbm_dat_i : 32'h0;
        end else begin
          timer_d = timer_q + 8'h1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      timer_q     <= 8'h0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      timer_q     <= timer_d;
    end
  end

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
Single-outstanding Wishbone classic (B3, non-pipelined) initiator that turns a simple valid/ready command stream into bus cycles toward user-area Wishbone responders (e.g. the operand/sum adder register at 0x3000_0000). It returns read data or a timeout error on a valid/ready response stream. It gives on-chip logic and test sequencers bus access without the management SoC.

Parameters:
BASE_ADDRESS, 32'h3000_0000, added to cmd_offset to form wbm_adr_o (32-bit wrap-around, carry discarded)
TIMEOUT_CYCLES, 16, max cycles cyc/stb stay asserted without ack before abort; legal range 1..255

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-high; clears all state immediately
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at clk edge
cmd_we  input  1  1 = write, 0 = read
cmd_offset  input  32  byte offset from BASE_ADDRESS
cmd_sel  input  4  byte selects
cmd_wdata  input  32  write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at clk edge
rsp_rdata  output  32  read data (0 for writes and errors)
rsp_err  output  1  1 = timeout, no ack received
busy  output  1  state != IDLE
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  Wishbone write enable
wbm_sel_o  output  4  Wishbone byte selects
wbm_adr_o  output  32  Wishbone address
wbm_dat_o  output  32  Wishbone write data
wbm_dat_i  input  32  Wishbone read data
wbm_ack_i  input  1  Wishbone acknowledge

Behaviour:
- Reset (async): state IDLE; wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timer=0. cmd_ready=0 while reset is high.
- State machine: IDLE -> BUS -> RESP -> IDLE. All Wishbone outputs and rsp_* are registered.
- cmd_ready = (state==IDLE) && !reset, combinational. busy is also combinational from state.
- IDLE: on handshake at edge N, register the following and enter BUS: wbm_adr_o = BASE_ADDRESS + cmd_offset, wbm_we_o = cmd_we, wbm_sel_o = cmd_sel, wbm_dat_o = cmd_wdata (reads: 0). cyc and stb go high after edge N.
- BUS: cyc=stb=1. Address, we, sel and data are held stable until the cycle ends. Timer cleared on entry and increments each BUS cycle without ack.
  - ack sampled high at an edge: cyc, stb and we drop after that edge. rsp_rdata = wbm_dat_i for reads, 0 for writes. rsp_err=0. Enter RESP.
  - Timeout: no ack at the edge where timer == TIMEOUT_CYCLES-1. cyc/stb drop (asserted exactly TIMEOUT_CYCLES cycles), rsp_rdata=0, rsp_err=1, enter RESP.
  - Ack and timeout at the same edge: ack wins, no error.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held until rsp_ready is sampled high; then rsp_valid=0 and state IDLE. cmd_ready stays low throughout RESP, so back-to-back commands need at least 3 cycles.
- Minimum latency for a responder that acks one cycle after stb: command accept edge N; cyc/stb high for cycles N+1..N+2; rsp_valid high from edge N+2.
- wbm_ack_i outside BUS (stray/late ack) is ignored and causes no state change.
- Reset mid-BUS: cyc/stb drop asynchronously and no response is generated. Reset mid-RESP: the pending response is discarded.
- Bus outputs not meaningful outside BUS are held at 0, except adr/sel, which keep their last values.

Test Plan:
- Write offset 0, cmd_wdata=0x0000_0053, sel=4'hF; responder acks in 2nd stb cycle -> adr=0x3000_0000, we=1, dat_o=0x53 stable, cyc/stb high exactly 2 cycles, rsp_valid with rsp_err=0, rsp_rdata=0.
- Read offset 0; responder acks with dat_i=0x0000_0008 -> we=0, rsp_rdata=0x0000_0008, rsp_err=0. Offset 0xD000_0004 -> adr wraps to 0x0000_0004.
- Read with no ack -> cyc/stb high exactly 16 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0; the next command completes normally.
- Ack at the final timeout cycle with dat_i=0xA5A5_A5A5 -> rsp_err=0, rsp_rdata=0xA5A5_A5A5.
- rsp_ready held low 5 cycles with cmd_valid high -> rsp_valid, rsp_rdata and rsp_err stable, cmd_ready=0, no second bus cycle until one cycle after rsp_ready.
- Reset pulsed in 1st BUS cycle -> cyc/stb low before the next clk edge, busy=0, no rsp_valid; a stray ack afterwards is ignored.
